// File: rtl/ysyx_22040759_if_axi_rd.sv
// IF fetch port to single-beat AXI4 read bridge: one outstanding read, 32-bit word zero-extended to 64.
// Latency: 3 cycles from request to if_ready with zero-wait slave; line-buffer hit (IF_LINE_BUF_EN) answers same cycle.
// Backpressure: arvalid held with stable araddr until arready; response held in RESP while if_valid is low.
module ysyx_22040759_if_axi_rd #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         AXI_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef IF_LINE_BUF_EN
    input  logic                  fence_i,
`endif
    input  logic                  if_valid,
    input  logic [63:0]           inst_addr,
    output logic                  if_ready,
    output logic [63:0]           if_data_read,
    output logic                  if_resp_err,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [AXI_ADDR_W-1:0] araddr,
    output logic [3:0]            arid,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [63:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic [3:0]            rid
);

    typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

    state_e                state_q;
    logic [63:0]           req_addr_q;
    logic [63:0]           line_q;
    logic                  err_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [AXI_ADDR_W-1:0] araddr_q;

    logic                  r_fire;
    logic                  resp_hs;
    logic                  lb_hit;
    logic [31:0]           word;

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign araddr  = araddr_q;
    assign rready  = rready_q;

    // Beats with a foreign rid are accepted (rready high) but never completed on.
    assign r_fire  = (state_q == R) && rvalid && (rid == AXI_ID) && rlast;
    assign resp_hs = (state_q == RESP) && if_valid && (inst_addr == req_addr_q);

`ifdef IF_LINE_BUF_EN
    logic        lb_valid_q;
    logic [60:0] lb_tag_q;
    logic [63:0] lb_data_q;

    assign lb_hit = (state_q == IDLE) && if_valid && lb_valid_q && (inst_addr[63:3] == lb_tag_q);

    // fence_i wins over a same-edge fill so a stale line never survives the fence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else if (fence_i) begin
            lb_valid_q <= 1'b0;
        end else if (r_fire && (rresp == 2'b00)) begin
            lb_valid_q <= 1'b1;
            lb_tag_q   <= req_addr_q[63:3];
            lb_data_q  <= rdata;
        end
    end
`else
    assign lb_hit = 1'b0;
`endif

    always_comb begin
        if_ready    = 1'b0;
        if_resp_err = 1'b0;
        word        = 32'b0;
        if (resp_hs) begin
            if_ready    = 1'b1;
            if_resp_err = err_q;
            word        = req_addr_q[2] ? line_q[63:32] : line_q[31:0];
        end
`ifdef IF_LINE_BUF_EN
        else if (lb_hit) begin
            if_ready = 1'b1;
            word     = inst_addr[2] ? lb_data_q[63:32] : lb_data_q[31:0];
        end
`endif
    end

    assign if_data_read = {32'b0, word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_valid && !lb_hit) begin
                        req_addr_q <= inst_addr;
                        araddr_q   <= {inst_addr[AXI_ADDR_W-1:3], 3'b000};
                        arvalid_q  <= 1'b1;
                        state_q    <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (r_fire) begin
                        line_q   <= rdata;
                        err_q    <= (rresp != 2'b00);
                        rready_q <= 1'b0;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // Matching address completes; any other address is a redirect refetched from IDLE.
                    if (if_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_if_axi_rd.sv
// Bench for the IF fetch AXI read bridge: randomized fetches against a transaction-level memory/slave model.
module tb_ysyx_22040759_if_axi_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [63:0] inst_addr;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic        if_resp_err;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;
`ifdef IF_LINE_BUF_EN
    logic        fence_i;
`endif

    always #5 clk = ~clk;

    ysyx_22040759_if_axi_rd dut (
        .clk(clk), .rst_n(rst_n),
`ifdef IF_LINE_BUF_EN
        .fence_i(fence_i),
`endif
        .if_valid(if_valid), .inst_addr(inst_addr), .if_ready(if_ready),
        .if_data_read(if_data_read), .if_resp_err(if_resp_err),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory model: each 8-byte aligned line has a content derived from its address.
    logic        use_fixed = 1'b0;
    logic [63:0] fixed_line = 64'h0;

    function automatic logic [63:0] mem_line(input logic [31:0] a);
        return {a ^ 32'h5A5A_0F0F, a + 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] line_for(input logic [63:0] addr);
        return use_fixed ? fixed_line : mem_line(addr[31:0] & 32'hFFFF_FFF8);
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] addr, input logic [63:0] line);
        return {32'b0, addr[2] ? line[63:32] : line[31:0]};
    endfunction

    // Slave configuration, set by the requester between transactions.
    int          cfg_ar_dly = 0;
    int          cfg_r_dly  = 0;
    bit          cfg_err    = 1'b0;
    bit          cfg_badid  = 1'b0;
    logic [31:0] exp_ar_q[$];
    int          ar_cnt = 0;

    task automatic r_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rr);
        bit done;
        done   = 1'b0;
        rvalid = 1'b1; rid = id; rdata = d; rresp = rr; rlast = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rready) done = 1'b1;
            @(posedge clk); #1;
        end
        chk("r_accept", done, 1);
        rvalid = 1'b0; rid = 4'd0; rdata = 64'h0; rresp = 2'b00; rlast = 1'b0;
    endtask

    initial begin : slave
        logic [31:0] ea;
        logic [63:0] line;
        arready = 1'b0; rvalid = 1'b0; rdata = 64'h0; rresp = 2'b00; rlast = 1'b0; rid = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && arvalid === 1'b1) begin
                if (exp_ar_q.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                    ea = araddr;
                end else begin
                    ea = exp_ar_q.pop_front();
                end
                for (int i = 0; i < cfg_ar_dly; i++) begin
                    chk("ar_hold", {arvalid, araddr}, {1'b1, ea});
                    @(negedge clk);
                end
                chk("araddr", araddr, ea);
                chk("ar_attr", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b011, 2'b01});
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                ar_cnt++;
                line = use_fixed ? fixed_line : mem_line(ea);
                repeat (cfg_r_dly) begin @(posedge clk); #1; end
                if (cfg_badid) r_beat(4'd1, ~line, 2'b00);
                r_beat(4'd0, line, cfg_err ? 2'b10 : 2'b00);
            end
        end
    end

    // Waits for if_ready at negedges; cyc counts negedges from the call (first = 0).
    task automatic wait_ready(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if_ready) begin
                ok = 1'b1; cyc = i;
                break;
            end
            chk("data_zero_when_not_ready", if_data_read, 64'h0);
        end
        if (!ok) chk("ready_timeout", 0, 1);
    endtask

    // mode 0: plain fetch; 1: address changed while the read is in flight; 2: redirect seen in RESP.
    task automatic fetch(input logic [63:0] a, input logic [63:0] b, input int mode,
                         input int stall, input int lat);
        bit          ok;
        int          cyc;
        int          ar0;
        logic [63:0] fin;
        ar0 = ar_cnt;
        fin = (mode != 0) ? b : a;
        exp_ar_q.push_back(a[31:0] & 32'hFFFF_FFF8);
        if (mode != 0) exp_ar_q.push_back(b[31:0] & 32'hFFFF_FFF8);
        if_valid = 1'b1; inst_addr = a;
        if (lat >= 0) begin
            wait_ready(ok, cyc);
            if (ok) chk("latency", cyc, lat);
        end else begin
            @(posedge clk); #1;
            if (mode == 1) inst_addr = b;
            if (stall > 0) begin
                if_valid = 1'b0;
                repeat (stall) begin
                    @(negedge clk);
                    chk("stall_no_ready", if_ready, 0);
                    @(posedge clk); #1;
                end
                if_valid = 1'b1;
            end
            wait_ready(ok, cyc);
            if (ok && mode == 2) begin
                inst_addr = b;
                #1;
                chk("redirect_no_ready", if_ready, 0);
                wait_ready(ok, cyc);
            end
        end
        if (ok) begin
            chk("data", if_data_read, exp_word(fin, line_for(fin)));
            chk("resp_err", if_resp_err, cfg_err);
        end
        @(posedge clk); #1;
        if_valid = 1'b0;
        chk("ar_count", ar_cnt - ar0, (mode != 0) ? 2 : 1);
        chk("ar_queue_drained", exp_ar_q.size(), 0);
        exp_ar_q.delete();
    endtask

    initial begin : main
        rst_n = 1'b0; if_valid = 1'b0; inst_addr = 64'h0;
`ifdef IF_LINE_BUF_EN
        fence_i = 1'b1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_resp_err", if_resp_err, 0);
        chk("rst_data", if_data_read, 64'h0);
        chk("rst_araddr", araddr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        use_fixed = 1'b1; fixed_line = 64'h0010_0093_0000_0013;
        fetch(64'h8000_0004, 64'h0, 0, 0, 3);
        chk("first_word", exp_word(64'h8000_0004, fixed_line), 64'h0000_0000_0010_0093);
        use_fixed = 1'b0;

        cfg_ar_dly = 5; cfg_r_dly = 3;
        fetch(64'h8000_0010, 64'h0, 0, 0, -1);

        cfg_ar_dly = 0; cfg_r_dly = 0;
        fetch(64'h8000_0024, 64'h0, 0, 8, -1);
        fetch(64'h8000_0030, 64'h8000_0100, 2, 0, -1);

        cfg_err = 1'b1; cfg_badid = 1'b1;
        fetch(64'h8000_0044, 64'h0, 0, 0, -1);
        cfg_err = 1'b0; cfg_badid = 1'b0;

        cfg_r_dly = 2;
        fetch(64'h8000_0050, 64'h8000_0204, 1, 0, -1);
        cfg_r_dly = 0;

`ifdef IF_LINE_BUF_EN
        begin : lb_test
            int ar0;
            fence_i = 1'b0;
            fetch(64'h8000_0000, 64'h0, 0, 0, -1);
            ar0 = ar_cnt;
            if_valid = 1'b1; inst_addr = 64'h8000_0004;
            @(negedge clk);
            chk("lb_hit_ready", if_ready, 1);
            chk("lb_hit_data", if_data_read, exp_word(64'h8000_0004, mem_line(32'h8000_0000)));
            chk("lb_hit_no_ar", arvalid, 0);
            @(posedge clk); #1;
            if_valid = 1'b0;
            @(negedge clk);
            chk("lb_hit_no_ar_after", arvalid, 0);
            chk("lb_hit_ar_count", ar_cnt - ar0, 0);
            @(posedge clk); #1;
            fence_i = 1'b1;
            @(posedge clk); #1;
            fence_i = 1'b0;
            fetch(64'h8000_0004, 64'h0, 0, 0, -1);
            fence_i = 1'b1;
        end
`endif

        for (int n = 0; n < 60; n++) begin
            logic [63:0] a;
            logic [63:0] b;
            int          mode;
            int          r;
            int          stall;
            cfg_ar_dly = $urandom_range(0, 4);
            cfg_r_dly  = $urandom_range(0, 4);
            cfg_err    = ($urandom_range(0, 3) == 0);
            cfg_badid  = ($urandom_range(0, 3) == 0);
            a = {(($urandom_range(0, 3) == 0) ? $urandom : 32'h0),
                 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
            b = a + 64'h8 * $urandom_range(1, 64);
            r = $urandom_range(0, 9);
            mode  = (r < 2) ? 1 : ((r < 4) ? 2 : 0);
            stall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            fetch(a, b, mode, stall, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
